// File: rtl/mold_udp_tx_framer_pkg.sv
// Shared header layouts, protocol constants and FSM encoding for the MoldUDP64 TX framer.
package mold_udp_tx_framer_pkg;

  localparam logic [47:0] DEVICE_MAC     = 48'h02_00_00_00_00_01;
  localparam logic [31:0] DEVICE_IP      = 32'hC0A8_0A01;
  localparam logic [15:0] ETH_IP_V4_TYPE = 16'h0800;
  localparam logic [7:0]  TTL            = 8'd64;
  localparam logic [7:0]  PROTOCOL       = 8'd17;

  localparam int ETH_HDR_LEN  = 14;
  localparam int IP_HDR_LEN   = 20;
  localparam int UDP_HDR_LEN  = 8;
  localparam int MOLD_HDR_LEN = 20;
  localparam int HDR_LEN      = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN + MOLD_HDR_LEN;
  localparam int IP_WORDS     = IP_HDR_LEN / 2;

  typedef enum logic [1:0] {IDLE, CHKSUM, HDR, PAYLOAD} state_t;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
  } eth_hdr_t;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] total_len;
    logic [15:0] id;
    logic [2:0]  flags;
    logic [12:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] chksum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ip_hdr_t;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] udp_len;
    logic [15:0] chksum;
  } udp_hdr_t;

  typedef struct packed {
    logic [79:0] session;
    logic [63:0] seq_num;
    logic [15:0] msg_cnt;
  } mold_hdr_t;

  // Fixed IPv4 fields: no options, ID 0, DF set, no fragmentation.
  function automatic ip_hdr_t mk_ip_hdr(input logic [15:0] total_len, input logic [15:0] chksum,
                                        input logic [31:0] src_ip, input logic [31:0] dst_ip);
    ip_hdr_t h;
    h.version   = 4'd4;
    h.ihl       = 4'd5;
    h.tos       = 8'h00;
    h.total_len = total_len;
    h.id        = 16'h0000;
    h.flags     = 3'b010;
    h.frag_off  = 13'd0;
    h.ttl       = TTL;
    h.protocol  = PROTOCOL;
    h.chksum    = chksum;
    h.src_ip    = src_ip;
    h.dst_ip    = dst_ip;
    return h;
  endfunction

endpackage

// File: rtl/ip_chksum_acc.sv
// 16-bit ones-complement accumulator; one word per cycle when i_add, carry folded back every add.
module ip_chksum_acc (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_add,
  input  logic [15:0] i_word,
  output logic [15:0] o_sum
);

  logic [15:0] r_acc;
  logic [16:0] w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, i_word};
  assign o_sum = r_acc;

  // Folding each step keeps r_acc a valid ones-complement sum: 0xFFFE + 1 cannot carry again.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= 16'h0000;
    end else if (i_clr) begin
      r_acc <= 16'h0000;
    end else if (i_add) begin
      r_acc <= w_sum[15:0] + {15'd0, w_sum[16]};
    end
  end

endmodule

// File: rtl/mold_udp_tx_framer.sv
// Builds Eth/IPv4/UDP/MoldUDP64 frames around an ITCH payload: 11-cycle checksum pass, 62 header bytes,
// then payload passed through combinationally. All byte movement is gated by txReadyIn.
module mold_udp_tx_framer
  import mold_udp_tx_framer_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = 48'h01005E000001,
  parameter logic [47:0] SRC_MAC     = DEVICE_MAC,
  parameter logic [31:0] SRC_IP      = DEVICE_IP,
  parameter logic [31:0] DST_IP      = 32'hE0000001,
  parameter logic [15:0] SRC_PORT    = 16'h4E20,
  parameter logic [15:0] DST_PORT    = 16'h4E21,
  parameter logic [79:0] SESS_ID     = 80'h4,
  parameter int          MAX_MSG_LEN = 1024
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        startIn,
  input  logic [15:0] msgLenIn,
  input  logic [7:0]  itchDataIn,
  input  logic        itchValidIn,
  output logic        itchReadyOut,
  output logic [7:0]  txDataOut,
  output logic        txValidOut,
  output logic        txLastOut,
  input  logic        txReadyIn,
  output logic        busyOut,
  output logic        errOut
);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, r_msg_len, r_chksum;
  logic [63:0] r_seq;
  logic        r_err;

  logic        w_len_ok, w_accept, w_fire, w_pay_last, w_hdr_done, w_chk_done;
  logic        w_acc_clr, w_acc_add;
  logic [15:0] w_ip_len, w_udp_len, w_acc_sum, w_acc_word;
  logic [5:0]  w_hdr_sel;

  eth_hdr_t    w_eth;
  ip_hdr_t     w_ip_calc, w_ip_tx;
  udp_hdr_t    w_udp;
  mold_hdr_t   w_mold;
  logic [IP_WORDS-1:0][15:0] w_ip_words;
  logic [HDR_LEN-1:0][7:0]   w_hdr_bytes;

  assign w_len_ok   = (msgLenIn != 16'd0) && (msgLenIn <= 16'(MAX_MSG_LEN));
  assign w_accept   = (r_state == IDLE) && startIn && w_len_ok;
  assign w_fire     = txValidOut && txReadyIn;
  assign w_pay_last = (r_cnt == r_msg_len - 16'd1);
  assign w_hdr_done = (r_cnt == 16'(HDR_LEN - 1));
  assign w_chk_done = (r_cnt == 16'(IP_WORDS));
  assign w_ip_len   = r_msg_len + 16'(IP_HDR_LEN + UDP_HDR_LEN + MOLD_HDR_LEN);
  assign w_udp_len  = r_msg_len + 16'(UDP_HDR_LEN + MOLD_HDR_LEN);

  assign w_eth       = '{dst_mac: DST_MAC, src_mac: SRC_MAC, eth_type: ETH_IP_V4_TYPE};
  assign w_ip_calc   = mk_ip_hdr(w_ip_len, 16'h0000, SRC_IP, DST_IP);
  assign w_ip_tx     = mk_ip_hdr(w_ip_len, r_chksum, SRC_IP, DST_IP);
  assign w_udp       = '{src_port: SRC_PORT, dst_port: DST_PORT, udp_len: w_udp_len, chksum: 16'h0000};
  assign w_mold      = '{session: SESS_ID, seq_num: r_seq, msg_cnt: 16'd1};
  assign w_hdr_bytes = {w_eth, w_ip_tx, w_udp, w_mold};
  assign w_ip_words  = w_ip_calc;

  // Byte 0 of the header sits in the most significant lane of the packed vector.
  assign w_hdr_sel  = 6'(HDR_LEN - 1) - r_cnt[5:0];
  assign w_acc_clr  = (r_state == IDLE);
  assign w_acc_add  = (r_state == CHKSUM) && (r_cnt < 16'(IP_WORDS));
  assign w_acc_word = w_acc_add ? w_ip_words[4'(IP_WORDS - 1) - r_cnt[3:0]] : 16'h0000;

  ip_chksum_acc u_chksum (
    .i_clk  (clkIn),
    .i_rst  (rstIn),
    .i_clr  (w_acc_clr),
    .i_add  (w_acc_add),
    .i_word (w_acc_word),
    .o_sum  (w_acc_sum)
  );

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = CHKSUM;
      CHKSUM:  if (w_chk_done) w_state_nxt = HDR;
      HDR:     if (w_fire && w_hdr_done) w_state_nxt = PAYLOAD;
      PAYLOAD: if (w_fire && w_pay_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    txValidOut   = 1'b0;
    txDataOut    = 8'h00;
    txLastOut    = 1'b0;
    itchReadyOut = 1'b0;
    busyOut      = 1'b1;
    unique case (r_state)
      IDLE:   busyOut = 1'b0;
      CHKSUM: busyOut = 1'b1;
      HDR: begin
        txValidOut = 1'b1;
        txDataOut  = w_hdr_bytes[w_hdr_sel];
      end
      PAYLOAD: begin
        txValidOut   = itchValidIn;
        txDataOut    = itchDataIn;
        txLastOut    = itchValidIn && w_pay_last;
        itchReadyOut = txReadyIn;
      end
      default: busyOut = 1'b0;
    endcase
  end

  assign errOut = r_err;

  // r_cnt is reused: checksum step, header byte index, payload byte index.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_cnt     <= 16'd0;
      r_msg_len <= 16'd0;
      r_chksum  <= 16'h0000;
      r_seq     <= 64'd1;
      r_err     <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) && startIn && !w_len_ok;
      unique case (r_state)
        IDLE: begin
          r_cnt <= 16'd0;
          if (w_accept) r_msg_len <= msgLenIn;
        end
        CHKSUM: begin
          if (w_chk_done) begin
            r_chksum <= ~w_acc_sum;
            r_cnt    <= 16'd0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        HDR: begin
          if (w_fire) r_cnt <= w_hdr_done ? 16'd0 : r_cnt + 16'd1;
        end
        PAYLOAD: begin
          if (w_fire) begin
            if (w_pay_last) begin
              r_cnt <= 16'd0;
              r_seq <= r_seq + 64'd1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        default: r_cnt <= 16'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mold_udp_tx_framer.sv
// Directed bench for mold_udp_tx_framer: captures accepted TX bytes and checks them against hand-built frames.
module tb_mold_udp_tx_framer;

  logic        clkIn = 1'b0;
  logic        rstIn = 1'b1;
  logic        startIn = 1'b0;
  logic [15:0] msgLenIn = 16'd0;
  logic [7:0]  itchDataIn = 8'h00;
  logic        itchValidIn = 1'b0;
  logic        itchReadyOut;
  logic [7:0]  txDataOut;
  logic        txValidOut;
  logic        txLastOut;
  logic        txReadyIn = 1'b1;
  logic        busyOut;
  logic        errOut;

  int errors = 0;
  int checks = 0;
  int stalls = 0;
  int stall_bad = 0;
  logic [7:0] cap[$];
  logic       lastq[$];
  logic [7:0] ref_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  logic       prev_last = 1'b0;

  // Expected 62-byte header for msgLen=36 with default parameters; seq bytes 52..59 filled per frame.
  logic [7:0] exp36 [62] = '{
    8'h01, 8'h00, 8'h5E, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h00,
    8'h45, 8'h00, 8'h00, 8'h54, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11, 8'h8F, 8'hEE,
    8'hC0, 8'hA8, 8'h0A, 8'h01, 8'hE0, 8'h00, 8'h00, 8'h01,
    8'h4E, 8'h20, 8'h4E, 8'h21, 8'h00, 8'h40, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h01};

  mold_udp_tx_framer dut (
    .clkIn        (clkIn),
    .rstIn        (rstIn),
    .startIn      (startIn),
    .msgLenIn     (msgLenIn),
    .itchDataIn   (itchDataIn),
    .itchValidIn  (itchValidIn),
    .itchReadyOut (itchReadyOut),
    .txDataOut    (txDataOut),
    .txValidOut   (txValidOut),
    .txLastOut    (txLastOut),
    .txReadyIn    (txReadyIn),
    .busyOut      (busyOut),
    .errOut       (errOut)
  );

  always #5 clkIn = ~clkIn;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Record each byte the MAC will accept on the next edge; flag output changes while stalled.
  always @(negedge clkIn) begin
    if (rstIn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        stalls++;
        if (!txValidOut || txDataOut !== prev_dat || txLastOut !== prev_last) stall_bad++;
      end
      if (txValidOut && txReadyIn) begin
        cap.push_back(txDataOut);
        lastq.push_back(txLastOut);
      end
      prev_stall = txValidOut && !txReadyIn;
      prev_dat   = txDataOut;
      prev_last  = txLastOut;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pay(input int i);
    return 8'((i * 7 + 17) & 255);
  endfunction

  function automatic logic [15:0] cap16(input int i);
    if (i + 1 < cap.size()) return {cap[i], cap[i+1]};
    return 16'h0000;
  endfunction

  function automatic logic [63:0] cap_seq();
    logic [63:0] s = 64'd0;
    for (int i = 52; i < 60; i++) s = {s[55:0], (i < cap.size()) ? cap[i] : 8'h00};
    return s;
  endfunction

  function automatic logic [15:0] ip_ones_sum();
    logic [15:0] s = 16'h0000;
    logic [16:0] t;
    for (int i = 0; i < 10; i++) begin
      t = {1'b0, s} + {1'b0, cap16(14 + 2 * i)};
      s = t[15:0] + {15'd0, t[16]};
    end
    return s;
  endfunction

  // Entered and left at posedge+1, so back-to-back calls assert startIn the cycle after the last byte.
  task automatic run_frame(input string tag, input logic [15:0] len, input bit stall);
    bit done = 1'b0;
    bit acc;
    bit seen = 1'b0;
    int pidx = 0;
    int pre = 0;
    cap.delete();
    lastq.delete();
    itchValidIn = 1'b1;
    itchDataIn  = pay(0);
    txReadyIn   = 1'b1;
    startIn     = 1'b1;
    msgLenIn    = len;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clkIn);
      if (txValidOut) seen = 1'b1;
      if (busyOut && !seen) pre++;
      acc  = itchValidIn && itchReadyOut;
      done = txValidOut && txReadyIn && txLastOut;
      @(posedge clkIn);
      #1;
      startIn = 1'b0;
      if (acc) pidx++;
      itchDataIn = pay(pidx);
      txReadyIn  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    itchValidIn = 1'b0;
    txReadyIn   = 1'b1;
    chk({tag, "_completed"}, 64'(done), 64'd1);
    chk({tag, "_chksum_cycles"}, 64'(pre), 64'd11);
  endtask

  task automatic check_frame(input string tag, input int len, input logic [63:0] seq);
    int nbad = 0;
    int nlast = 0;
    int lastpos = -1;
    chk({tag, "_size"}, 64'(cap.size()), 64'(len + 62));
    chk({tag, "_ip_len"}, 64'(cap16(16)), 64'(len + 48));
    chk({tag, "_udp_len"}, 64'(cap16(38)), 64'(len + 28));
    chk({tag, "_mold_len"}, 64'(cap.size() - 62), 64'(len));
    chk({tag, "_hdr_ones_sum"}, 64'(ip_ones_sum()), 64'hFFFF);
    chk({tag, "_seq"}, cap_seq(), seq);
    for (int i = 0; i < len && 62 + i < cap.size(); i++)
      if (cap[62 + i] !== pay(i)) nbad++;
    chk({tag, "_payload_bad"}, 64'(nbad), 64'd0);
    for (int i = 0; i < lastq.size(); i++)
      if (lastq[i]) begin nlast++; lastpos = i; end
    chk({tag, "_last_count"}, 64'(nlast), 64'd1);
    chk({tag, "_last_pos"}, 64'(lastpos), 64'(len + 61));
  endtask

  task automatic check_hdr36(input string tag, input logic [63:0] seq);
    int nbad = 0;
    logic [7:0] e;
    for (int i = 0; i < 62 && i < cap.size(); i++) begin
      e = (i >= 52 && i < 60) ? 8'(seq >> (8 * (59 - i))) : exp36[i];
      if (cap[i] !== e) nbad++;
    end
    chk({tag, "_hdr_bytes_bad"}, 64'(nbad), 64'd0);
  endtask

  task automatic err_test(input string tag, input logic [15:0] len);
    cap.delete();
    itchValidIn = 1'b1;
    startIn     = 1'b1;
    msgLenIn    = len;
    @(posedge clkIn);
    #1;
    startIn = 1'b0;
    @(negedge clkIn);
    chk({tag, "_err_pulse"}, 64'(errOut), 64'd1);
    chk({tag, "_busy_idle"}, 64'(busyOut), 64'd0);
    @(negedge clkIn);
    chk({tag, "_err_cleared"}, 64'(errOut), 64'd0);
    chk({tag, "_busy_still_idle"}, 64'(busyOut), 64'd0);
    repeat (20) @(negedge clkIn);
    chk({tag, "_no_tx"}, 64'(cap.size()), 64'd0);
    @(posedge clkIn);
    #1;
    itchValidIn = 1'b0;
  endtask

  initial begin
    bit hit;
    int nlast;
    int nbad;

    repeat (3) @(posedge clkIn);
    @(negedge clkIn);
    chk("rst_txValid", 64'(txValidOut), 64'd0);
    chk("rst_txLast", 64'(txLastOut), 64'd0);
    chk("rst_txData", 64'(txDataOut), 64'd0);
    chk("rst_itchReady", 64'(itchReadyOut), 64'd0);
    chk("rst_busy", 64'(busyOut), 64'd0);
    chk("rst_err", 64'(errOut), 64'd0);
    @(posedge clkIn);
    #1;
    rstIn = 1'b0;
    @(posedge clkIn);
    #1;

    run_frame("f1", 16'd36, 1'b0);
    check_frame("f1", 36, 64'd1);
    check_hdr36("f1", 64'd1);
    chk("f1_ip_len_hex", 64'(cap16(16)), 64'h0054);
    chk("f1_udp_len_hex", 64'(cap16(38)), 64'h0040);
    chk("f1_mold_len_hex", 64'(cap.size() - 62), 64'h0024);
    ref_q = cap;

    run_frame("f2", 16'd36, 1'b0);
    check_frame("f2", 36, 64'd2);
    check_hdr36("f2", 64'd2);

    stalls    = 0;
    stall_bad = 0;
    run_frame("stall", 16'd36, 1'b1);
    check_frame("stall", 36, 64'd3);
    nbad = 0;
    for (int i = 0; i < ref_q.size() && i < cap.size(); i++)
      if (!(i >= 52 && i < 60) && cap[i] !== ref_q[i]) nbad++;
    chk("stall_same_bytes_bad", 64'(nbad), 64'd0);
    chk("stall_unstable", 64'(stall_bad), 64'd0);
    chk("stall_seen", 64'(stalls > 0), 64'd1);

    err_test("len0", 16'd0);
    err_test("len1025", 16'd1025);

    run_frame("min", 16'd1, 1'b0);
    check_frame("min", 1, 64'd4);
    run_frame("max", 16'd1024, 1'b0);
    check_frame("max", 1024, 64'd5);
    chk("max_ip_len_hex", 64'(cap16(16)), 64'h0430);

    cap.delete();
    lastq.delete();
    itchValidIn = 1'b1;
    itchDataIn  = pay(0);
    txReadyIn   = 1'b1;
    startIn     = 1'b1;
    msgLenIn    = 16'd36;
    @(posedge clkIn);
    #1;
    startIn = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clkIn);
      #1;
      if (cap.size() == 31 && txValidOut) hit = 1'b1;
    end
    chk("midrst_reached_byte30", 64'(hit), 64'd1);
    rstIn = 1'b1;
    #1;
    chk("midrst_txValid", 64'(txValidOut), 64'd0);
    chk("midrst_txLast", 64'(txLastOut), 64'd0);
    chk("midrst_busy", 64'(busyOut), 64'd0);
    nlast = 0;
    foreach (lastq[i]) if (lastq[i]) nlast++;
    chk("midrst_no_last", 64'(nlast), 64'd0);
    itchValidIn = 1'b0;
    @(posedge clkIn);
    @(posedge clkIn);
    #1;
    rstIn = 1'b0;
    @(posedge clkIn);
    #1;

    run_frame("after_rst", 16'd36, 1'b0);
    check_frame("after_rst", 36, 64'd1);
    check_hdr36("after_rst", 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
